// File: rtl/alu_operand_loader.sv
// alu_operand_loader: assembles operand A, operand B and a 4-bit opcode from a
// serial MSB-first nibble stream, then presents one ALU command via valid/ready.
// Optional issue timeout with sticky err: define ALU_LOADER_TIMEOUT_EN.
module alu_operand_loader #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [3:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [3:0]       opcode,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic             busy,
  output logic             err
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] StLoadA  = 2'd0;
  localparam logic [1:0] StLoadB  = 2'd1;
  localparam logic [1:0] StLoadOp = 2'd2;
  localparam logic [1:0] StIssue  = 2'd3;

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and >= 4");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be >= 2");
  end

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [3:0]       opcode_q, opcode_d;
  logic             alu_valid_q, alu_valid_d;

  logic accept;
  logic hs;
  logic cnt_last;
  logic tmo_fire;

  assign in_ready = ena & ~reset & (state_q != StIssue);
  assign accept   = in_valid & in_ready;
  // A handshake only counts while the block is enabled.
  assign hs       = ena & alu_valid_q & alu_ready;
  assign cnt_last = (cnt_q == CW'(NIB - 1));

`ifdef ALU_LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Handshake on the same edge wins over the timeout.
  assign tmo_fire = ena & (state_q == StIssue) & ~hs & (tmo_q == TW'(TIMEOUT - 1));

  // Issue wait counter and sticky error next-state.
  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    if (hs || tmo_fire) begin
      tmo_d = '0;
    end else if (ena && state_q == StIssue) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (tmo_fire) begin
      err_d = 1'b1;
    end
  end

  // Timeout state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_fire = 1'b0;
  assign err      = 1'b0;
`endif

  // Load FSM: shift nibbles into operands, capture opcode, then issue.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    opcode_d    = opcode_q;
    alu_valid_d = alu_valid_q;
    case (state_q)
      StLoadA: begin
        if (accept) begin
          // First nibble of a command clears any stale high bits.
          op_a_d = (cnt_q == '0) ? WIDTH'(in_data) : ((op_a_q << 4) | WIDTH'(in_data));
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = StLoadB;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StLoadB: begin
        if (accept) begin
          op_b_d = (cnt_q == '0) ? WIDTH'(in_data) : ((op_b_q << 4) | WIDTH'(in_data));
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = StLoadOp;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StLoadOp: begin
        if (accept) begin
          opcode_d    = in_data;
          alu_valid_d = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (hs || tmo_fire) begin
          alu_valid_d = 1'b0;
          state_d     = StLoadA;
        end
      end
      default: begin
        state_d = StLoadA;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath and FSM registers; reset overrides ena.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StLoadA;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      opcode_q    <= '0;
      alu_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      opcode_q    <= opcode_d;
      alu_valid_q <= alu_valid_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign opcode    = opcode_q;
  assign alu_valid = alu_valid_q;
  assign busy      = (state_q != StLoadA) | (cnt_q != '0);

endmodule

// File: tb/tb_alu_operand_loader.sv
// Testbench for alu_operand_loader (WIDTH=8): table-driven commands with a
// scoreboard queue, plus hand sequences for ena freeze, mid-load reset, timeout.
module tb_alu_operand_loader;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         ena;
  logic [3:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   opcode;
  logic         alu_valid;
  logic         alu_ready;
  logic         busy;
  logic         err;

  alu_operand_loader #(.WIDTH(W), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .opcode    (opcode),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:4][3:0] nibs;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [3:0]      op;
    bit              gaps;
    int              hold;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one nibble from a negedge and return on the edge that accepts it.
  task automatic send_nib(input logic [3:0] d);
    int n;
    @(negedge clk);
    ena      = 1'b1;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("nib_accept_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic send_cmd(input vec_t v);
    for (int i = 0; i < 5; i++) begin
      send_nib(v.nibs[i]);
      if (v.gaps && i < 4) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    sb.push_back('{a: v.a, b: v.b, op: v.op});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the negedge after the opcode nibble is accepted.
  task automatic check_issue();
    chk("valid_after_op", {31'd0, alu_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
      cur = '0;
    end else begin
      cur = sb.pop_front();
    end
    chk("op_a", {24'd0, op_a}, {24'd0, cur.a});
    chk("op_b", {24'd0, op_b}, {24'd0, cur.b});
    chk("opcode", {28'd0, opcode}, {28'd0, cur.op});
    in_valid = 1'b1;
    #1;
    chk("in_ready_issue", {31'd0, in_ready}, 32'd0);
    chk("busy_issue", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic handshake(input int hold);
    alu_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, alu_valid}, 32'd1);
      chk("hold_stable", {op_a, op_b, opcode}, {cur.a, cur.b, cur.op});
    end
    alu_ready = 1'b1;
    @(negedge clk);
    alu_ready = 1'b0;
    chk("valid_drop", {31'd0, alu_valid}, 32'd0);
    chk("ready_after_hs", {31'd0, in_ready}, 32'd1);
    chk("busy_after_hs", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_op_a"}, {24'd0, op_a}, 32'd0);
    chk({tag, "_op_b"}, {24'd0, op_b}, 32'd0);
    chk({tag, "_opcode"}, {28'd0, opcode}, 32'd0);
    chk({tag, "_valid"}, {31'd0, alu_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  vec_t tbl[5];
  vec_t v;

  initial begin
    int n;
    tbl[0] = '{nibs: {4'hA, 4'h5, 4'h3, 4'hC, 4'h2}, a: 8'hA5, b: 8'h3C, op: 4'h2, gaps: 0, hold: 5};
    tbl[1] = '{nibs: {4'hF, 4'hF, 4'h0, 4'h1, 4'h7}, a: 8'hFF, b: 8'h01, op: 4'h7, gaps: 0, hold: 0};
    tbl[2] = '{nibs: {4'hA, 4'h5, 4'h3, 4'hC, 4'h2}, a: 8'hA5, b: 8'h3C, op: 4'h2, gaps: 1, hold: 2};
    tbl[3] = '{nibs: {4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, a: 8'h00, b: 8'h00, op: 4'h0, gaps: 0, hold: 1};
    tbl[4] = '{nibs: {4'h8, 4'h1, 4'hE, 4'h7, 4'hF}, a: 8'h81, b: 8'hE7, op: 4'hF, gaps: 1, hold: 3};

    reset     = 1'b1;
    ena       = 1'b1;
    in_data   = 4'h0;
    in_valid  = 1'b1;
    alu_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_in_reset", {31'd0, in_ready}, 32'd0);
    check_zero("reset");
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      send_cmd(tbl[i]);
      check_issue();
      handshake(tbl[i].hold);
    end

    // ena low mid-load: offered nibble must not be consumed.
    send_nib(4'h9);
    send_nib(4'h4);
    send_nib(4'h1);
    @(negedge clk);
    ena      = 1'b0;
    in_data  = 4'h8;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("ena_low_ready", {31'd0, in_ready}, 32'd0);
      chk("ena_low_busy", {31'd0, busy}, 32'd1);
    end
    send_nib(4'h8);
    send_nib(4'h6);
    sb.push_back('{a: 8'h94, b: 8'h18, op: 4'h6});
    @(negedge clk);
    in_valid = 1'b0;
    check_issue();
    // Handshake while disabled is ignored.
    ena       = 1'b0;
    alu_ready = 1'b1;
    @(negedge clk);
    chk("ena_low_hs_ignored", {31'd0, alu_valid}, 32'd1);
    ena = 1'b1;
    handshake(0);

    // Reset in LOAD_B after three nibbles.
    send_nib(4'h1);
    send_nib(4'h2);
    send_nib(4'h3);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b0;
    v = '{nibs: {4'h1, 4'h2, 4'h3, 4'h4, 4'h5}, a: 8'h12, b: 8'h34, op: 4'h5, gaps: 0, hold: 0};
    send_cmd(v);
    check_issue();
    handshake(1);

    // Long wait in ISSUE.
    v = '{nibs: {4'hC, 4'h3, 4'h5, 4'hA, 4'h9}, a: 8'hC3, b: 8'h5A, op: 4'h9, gaps: 0, hold: 0};
    send_cmd(v);
    check_issue();
`ifdef ALU_LOADER_TIMEOUT_EN
    n = 0;
    while (alu_valid === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_cycles", n, 32'd16);
    chk("timeout_err", {31'd0, err}, 32'd1);
    chk("timeout_keep_a", {24'd0, op_a}, 32'hC3);
    send_cmd(tbl[1]);
    check_issue();
    handshake(0);
    chk("err_sticky", {31'd0, err}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("err_cleared", {31'd0, err}, 32'd0);
`else
    n = 0;
    repeat (100) @(negedge clk);
    chk("no_timeout_valid", {31'd0, alu_valid}, 32'd1);
    chk("no_timeout_err", {31'd0, err}, 32'd0);
    handshake(0);
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
